// File: rtl/bit_framer_pkg.sv
// Shared types and constants for the bit framer.
package bit_framer_pkg;

   localparam int unsigned PRE_LEN_DEF   = 16;
   localparam logic [7:0]  SYNC_WORD_DEF = 8'hA7;
   localparam int unsigned BYTE_W        = 8;
   localparam int unsigned LEN_W         = 8;
   localparam int unsigned PRE_CNT_W     = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_SYNC,
      ST_LEN,
      ST_PAY
   } state_e;

endpackage

// File: rtl/bit_framer_piso8.sv
// 8-bit load/shift serialiser, MSB first, with bit index and last-bit flag.
module piso8
   import bit_framer_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [BYTE_W-1:0] din_i,
   output logic              bit_o,
   output logic              last_o,
   output logic              full_o
);

   logic [BYTE_W-1:0] sh_q, sh_d;
   logic [2:0]        idx_q, idx_d;
   logic              full_q, full_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sh_q   <= '0;
         idx_q  <= '0;
         full_q <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         idx_q  <= idx_d;
         full_q <= full_d;
      end
   end

   // When empty, a load with shift consumes din_i[7] directly so the first bit costs no cycle.
   always_comb begin
      sh_d   = sh_q;
      idx_d  = idx_q;
      full_d = full_q;
      if (full_q && shift_i) begin
         if (idx_q == 3'd7) begin
            if (load_i) begin
               sh_d  = din_i;
               idx_d = '0;
            end else begin
               full_d = 1'b0;
            end
         end else begin
            sh_d  = {sh_q[BYTE_W-2:0], 1'b0};
            idx_d = idx_q + 3'd1;
         end
      end else if (!full_q && load_i) begin
         full_d = 1'b1;
         if (shift_i) begin
            sh_d  = {din_i[BYTE_W-2:0], 1'b0};
            idx_d = 3'd1;
         end else begin
            sh_d  = din_i;
            idx_d = '0;
         end
      end
   end

   assign bit_o  = full_q ? sh_q[BYTE_W-1] : din_i[BYTE_W-1];
   assign last_o = full_q && (idx_q == 3'd7);
   assign full_o = full_q;

endmodule

// File: rtl/bit_framer.sv
// Serial frame generator: preamble, sync byte, length byte, payload bytes (MSB first).
module bit_framer
   import bit_framer_pkg::*;
#(
   parameter int unsigned PRE_LEN   = PRE_LEN_DEF,
   parameter logic [7:0]  SYNC_WORD = SYNC_WORD_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              byte_valid_i,
   input  logic [BYTE_W-1:0] byte_i,
   output logic              byte_ready_o,
   output logic              valid_o,
   output logic              data_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam logic [PRE_CNT_W-1:0] PRE_LAST = PRE_CNT_W'(PRE_LEN - 1);

   state_e                state_q, state_d;
   logic [PRE_CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
   logic [LEN_W-1:0]      cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  valid_q, valid_d;
   logic                  data_q, data_d;

   logic                  emit, ready, take;
   logic                  p_load, p_shift, p_bit, p_last, p_full;
   logic [BYTE_W-1:0]     p_din;

   piso8 u_piso (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .load_i  (p_load),
      .shift_i (p_shift),
      .din_i   (p_din),
      .bit_o   (p_bit),
      .last_o  (p_last),
      .full_o  (p_full)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= ST_IDLE;
         pre_cnt_q <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         data_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
      end
   end

   // IDLE with busy still set is the cycle showing the last bit; done follows it.
   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (busy_q) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end else if (start_i && !done_q) begin
               state_d   = ST_PRE;
               pre_cnt_d = '0;
               cnt_d     = len_i;
               busy_d    = 1'b1;
            end
         end
         ST_PRE: begin
            pre_cnt_d = pre_cnt_q + PRE_CNT_W'(1);
            if (pre_cnt_q == PRE_LAST) state_d = ST_SYNC;
         end
         ST_SYNC: begin
            if (p_last) state_d = ST_LEN;
         end
         ST_LEN: begin
            if (p_last) state_d = (cnt_q == '0) ? ST_IDLE : ST_PAY;
         end
         ST_PAY: begin
            if (take) cnt_d = cnt_q - LEN_W'(1);
            if (p_last && (cnt_q == '0)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      p_din = byte_i;
      case (state_q)
         ST_PRE:  p_din = SYNC_WORD;
         ST_SYNC: p_din = cnt_q;
         default: p_din = byte_i;
      endcase
   end

   always_comb begin
      emit    = 1'b0;
      ready   = 1'b0;
      take    = 1'b0;
      p_load  = 1'b0;
      p_shift = 1'b0;
      data_d  = data_q;
      unique case (state_q)
         ST_PRE: begin
            emit   = 1'b1;
            data_d = ~pre_cnt_q[0];
            p_load = (pre_cnt_q == PRE_LAST);
         end
         ST_SYNC: begin
            emit    = 1'b1;
            p_shift = 1'b1;
            p_load  = p_last;
            data_d  = p_bit;
         end
         ST_LEN: begin
            emit    = 1'b1;
            p_shift = 1'b1;
            data_d  = p_bit;
         end
         ST_PAY: begin
            ready   = (cnt_q != '0) && (!p_full || p_last);
            take    = ready && byte_valid_i;
            emit    = p_full || take;
            p_shift = emit;
            p_load  = take;
            if (emit) data_d = p_bit;
         end
         default: ;
      endcase
      valid_d = emit;
   end

   assign byte_ready_o = ready;
   assign valid_o      = valid_q;
   assign data_o       = data_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_bit_framer.sv
// Self-checking bench for bit_framer: frame-level bit model, per-cycle compare, directed scenarios.
module tb_bit_framer;

   localparam int PRE_LEN = 16;

   logic       CLK, RST, start_i, byte_valid_i;
   logic [7:0] len_i, byte_i;
   logic       byte_ready_o, valid_o, data_o, busy_o, done_o;

   bit_framer #(.PRE_LEN(PRE_LEN), .SYNC_WORD(8'hA7)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .start_i      (start_i),
      .len_i        (len_i),
      .byte_valid_i (byte_valid_i),
      .byte_i       (byte_i),
      .byte_ready_o (byte_ready_o),
      .valid_o      (valid_o),
      .data_o       (data_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int         n_cmp = 0, n_bad = 0;
   bit         exp_q[$];
   bit         build_q[$];
   logic [7:0] fb[$];
   int         fidx = 0, stall_idx = -1, stall_left = 0;
   bit         xfer = 1'b0;
   bit         mon_en = 1'b0, done_pend = 1'b0;
   logic       last_data = 1'b0;
   int         sym_cnt = 0, gaps = 0, ready_cnt = 0, cur_len = 0, frames_done = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic void push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) build_q.push_back(b[i]);
   endfunction

   // Frame as a flat bit list straight from the frame layout.
   function automatic void build(input int len);
      build_q.delete();
      for (int i = 0; i < PRE_LEN; i++) build_q.push_back((i % 2) == 0);
      push_byte(8'hA7);
      push_byte(8'(len));
      for (int i = 0; i < len; i++) push_byte(fb[i]);
   endfunction

   // Monitor: compare every output cycle against the expected bit list.
   initial begin
      bit exp_done;
      bit eb;
      int xr;
      forever begin
         @(negedge CLK);
         if (mon_en) begin
            exp_done  = done_pend;
            done_pend = 1'b0;
            if (valid_o) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_bit", 1, 0);
               end else begin
                  eb = exp_q.pop_front();
                  chk("frame_bit", data_o, eb);
                  xr = data_o ? 8 : -8;
                  chk("mapper_xr", xr, eb ? 8 : -8);
                  sym_cnt++;
                  if (exp_q.size() == 0) done_pend = 1'b1;
               end
               last_data = data_o;
            end else begin
               chk("data_hold", data_o, last_data);
               if (sym_cnt > 0 && exp_q.size() > 0) gaps++;
            end
            if (byte_ready_o) ready_cnt++;
            chk("done_pulse", done_o, exp_done);
            if (exp_done) begin
               chk("busy_fall", busy_o, 0);
               chk("symbol_count", sym_cnt, PRE_LEN + 16 + 8 * cur_len);
               frames_done++;
            end
         end
      end
   end

   // Payload source; a stall holds valid low for stall_left cycles in which ready is seen.
   initial begin
      forever begin
         @(negedge CLK);
         xfer = byte_valid_i && byte_ready_o;
         if (!byte_valid_i && byte_ready_o && fidx == stall_idx && stall_left > 0) stall_left--;
         @(posedge CLK);
         #2;
         if (xfer) fidx++;
         xfer = 1'b0;
         if (fidx < fb.size() && !(fidx == stall_idx && stall_left > 0)) begin
            byte_valid_i = 1'b1;
            byte_i       = fb[fidx];
         end else begin
            byte_valid_i = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start_frame(input int len);
      build(len);
      foreach (build_q[i]) exp_q.push_back(build_q[i]);
      cur_len   = len;
      sym_cnt   = 0;
      gaps      = 0;
      ready_cnt = 0;
      fidx      = 0;
      start_i   = 1'b1;
      len_i     = 8'(len);
      tick();
      start_i = 1'b0;
      chk("lat_valid_low", valid_o, 0);
      chk("lat_busy", busy_o, 1);
      tick();
      chk("lat_first_bit", {valid_o, data_o}, 2'b11);
   endtask

   task automatic wait_done(input int bound);
      int f0;
      int k;
      f0 = frames_done;
      k  = 0;
      while (frames_done == f0 && k < bound) begin
         tick();
         k++;
      end
      chk("frame_completed", frames_done != f0, 1);
   endtask

   task automatic pulse_start_mid();
      repeat (10) tick();
      start_i = 1'b1;
      len_i   = 8'd7;
      tick();
      start_i = 1'b0;
   endtask

   initial begin
      logic [47:0] v48;
      logic [31:0] v32;
      int k;
      RST = 1'b0; start_i = 1'b0; len_i = '0; byte_valid_i = 1'b0; byte_i = '0;
      #3;
      chk("rst_valid", valid_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_ready", byte_ready_o, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      mon_en = 1'b1;
      tick();

      // Two bytes, always valid.
      fb = '{8'h01, 8'hFF};
      build(2);
      v48 = '0;
      foreach (build_q[i]) v48 = {v48[46:0], build_q[i]};
      chk("model_len2_size", build_q.size(), 48);
      chk("model_len2_bits", v48, 48'hAAAA_A702_01FF);
      start_frame(2);
      wait_done(200);
      chk("len2_gaps", gaps, 0);
      chk("len2_bytes_taken", fidx, 2);

      // Empty payload.
      fb.delete();
      build(0);
      v32 = '0;
      foreach (build_q[i]) v32 = {v32[30:0], build_q[i]};
      chk("model_len0_size", build_q.size(), 32);
      chk("model_len0_bits", v32, 32'hAAAA_A700);
      start_frame(0);
      wait_done(200);
      chk("len0_ready_never", ready_cnt, 0);

      // Underrun before the second byte: first ready cycle overlaps the last bit, then 5 starved cycles.
      fb = '{8'h3C, 8'h5A, 8'hC3};
      stall_idx  = 1;
      stall_left = 6;
      start_frame(3);
      wait_done(300);
      chk("underrun_gaps", gaps, 5);
      stall_idx = -1;

      // start_i ignored mid-frame, in the last-bit cycle and in the done cycle.
      fb = '{8'h96};
      start_frame(1);
      pulse_start_mid();
      k = 0;
      while (!(valid_o && exp_q.size() == 1) && k < 300) begin
         tick();
         k++;
      end
      chk("reached_last_bit", valid_o && exp_q.size() == 1, 1);
      start_i = 1'b1;
      tick();
      chk("done_cycle", done_o, 1);
      tick();
      start_i = 1'b0;
      chk("ignored_busy", busy_o, 0);
      tick();
      chk("ignored_valid", valid_o, 0);
      chk("ignored_busy2", busy_o, 0);
      repeat (3) tick();

      // Back-to-back: start in the cycle right after done.
      fb = '{8'h5A};
      start_frame(1);
      pulse_start_mid();
      k = 0;
      while (!done_o && k < 300) begin
         tick();
         k++;
      end
      chk("b2b_done_seen", done_o, 1);
      tick();
      fb = '{8'h0F, 8'hF0};
      start_frame(2);
      wait_done(300);
      chk("b2b_gaps", gaps, 0);

      // Reset in the middle of the payload.
      fb = '{8'h11, 8'h22, 8'h33, 8'h44};
      start_frame(4);
      k = 0;
      while (fidx < 2 && k < 300) begin
         tick();
         k++;
      end
      chk("reached_byte2", fidx, 2);
      #2;
      mon_en = 1'b0;
      RST    = 1'b0;
      #1;
      chk("midrst_valid", valid_o, 0);
      chk("midrst_data", data_o, 0);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_done", done_o, 0);
      chk("midrst_ready", byte_ready_o, 0);
      exp_q.delete();
      fb.delete();
      done_pend = 1'b0;
      last_data = 1'b0;
      @(negedge CLK);
      RST    = 1'b1;
      mon_en = 1'b1;
      repeat (20) tick();
      chk("post_rst_idle_busy", busy_o, 0);

      // Maximum length.
      fb.delete();
      for (int i = 0; i < 255; i++) fb.push_back(8'((i * 37 + 11) & 8'hFF));
      start_frame(255);
      wait_done(2500);
      chk("len255_bytes_taken", fidx, 255);
      chk("len255_gaps", gaps, 0);
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
